pll_reconfig_arbiter: RTL

- Shares the single PLL reconfiguration control state machine among NUM_REQ independent requesters.
- Arbitrates requests round-robin and issues a one-cycle reconfig strobe with the selected ROM profile index.
- Tracks the control FSM's state output to detect completion, then returns a one-cycle done pulse to the granted requester.
- Skips the reconfiguration entirely when the requested profile is already loaded.

---
 rtl/pll_reconfig_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/pll_reconfig_arbiter.sv
// pll_reconfig_arbiter: round-robin sharing of one PLL reconfig control FSM; PLL_RECONF_ARB_TIMEOUT_EN adds a wait watchdog
module pll_reconfig_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ROM_W          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROM_W-1:0] req_rom,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     arb_busy,
  output logic                     want_to_reconfig,
  output logic [ROM_W-1:0]         intended_rom,
  input  logic [2:0]               sm_state,
  output logic [ROM_W-1:0]         loaded_rom,
  output logic                     err
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, ACK} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gidx, sel_idx;
  logic [ROM_W-1:0] sel_rom;
  logic [NUM_REQ-1:0] sel_oh;
  logic tmo;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_reconfig_arbiter: parameter out of range");
  end
  // first requester at or after rr_ptr, wrapping; lowest offset wins
  always_comb begin
    sel_idx = '0;
    sel_rom = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
        sel_rom = req_rom[((int'(rr_ptr) + k) % NUM_REQ) * ROM_W +: ROM_W];
      end
    sel_oh = NUM_REQ'(1) << sel_idx;
  end
  // next state: cache hits bypass the control FSM entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = |req ? (sel_rom == loaded_rom ? ACK : ISSUE) : IDLE;
      ISSUE:      state_nx = WAIT_START;
      WAIT_START: state_nx = sm_state != 3'd0 ? WAIT_DONE : (tmo ? ACK : WAIT_START);
      WAIT_DONE:  state_nx = (sm_state == 3'd0 || tmo) ? ACK : WAIT_DONE;
      default:    state_nx = IDLE;
    endcase
  end
  // state and all outputs registered so pulses carry no input-to-output paths
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      gidx             <= '0;
      grant            <= '0;
      done             <= '0;
      want_to_reconfig <= 1'b0;
      intended_rom     <= '0;
      loaded_rom       <= '0;
    end else begin
      state            <= state_nx;
      want_to_reconfig <= state_nx == ISSUE;
      intended_rom     <= state_nx == ISSUE ? sel_rom : intended_rom;
      grant            <= (state == IDLE && |req) ? sel_oh : (state == ACK ? '0 : grant);
      gidx             <= (state == IDLE && |req) ? sel_idx : gidx;
      done             <= state_nx == ACK ? (state == IDLE ? sel_oh : grant) : '0;
      loaded_rom       <= (state == WAIT_DONE && sm_state == 3'd0) ? intended_rom : loaded_rom;
      rr_ptr           <= state == ACK ? (int'(gidx) == NUM_REQ - 1 ? '0 : gidx + IW'(1)) : rr_ptr;
    end
  end
  assign arb_busy = state != IDLE;
`ifdef PLL_RECONF_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  assign tmo = wait_cnt == 32'(TIMEOUT_CYCLES - 1) &&
               (state == WAIT_START ? sm_state == 3'd0 : (state == WAIT_DONE && sm_state != 3'd0));
  // watchdog restarts on every state change and latches err on expiry
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= state_nx != state ? '0 : wait_cnt + 32'd1;
      err      <= err | tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule
